cell_load_sequencer: RTL and testbench

Frame-level controller that drives the CellProcessor datapath. It accepts a stream of paired 24-bit pixels (A and B images) over a valid/ready handshake and packs each run of 9 into the 216-bit cellA/cellB vectors. It holds those vectors stable for a fixed processing latency, then captures processedPixel and presents it downstream with valid/ready. It counts cells per frame and signals frame completion. It sits between the pixel source (loader/DMA) and the CellProcessor instance, replacing testbench-side sequencing.

---
 rtl/cell_load_sequencer.sv | 140 ++++++++++++++
 tb/tb_cell_load_sequencer.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/cell_load_sequencer.sv
// rtl/cell_load_sequencer.sv - packs pixel pairs into 3x3 cells and sequences CellProcessor results
// One cell at a time: load 9 beats, hold for the processing latency, hand the result downstream.
module cell_load_sequencer #(
  parameter int PIXEL_W      = 24,
  parameter int CELL_PIXELS  = 9,
  parameter int CELL_W       = PIXEL_W * CELL_PIXELS,
  parameter int PROC_LATENCY = 4,
  parameter int NUM_CELLS    = 16,
  parameter int OPCODE_W     = 4,
  parameter int CNT_W        = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  input  logic [OPCODE_W-1:0] cfg_opcode,
  input  logic [PIXEL_W-1:0]  cfg_user_input,
  input  logic                pix_valid,
  output logic                pix_ready,
  input  logic [31:0]         pix_a,
  input  logic [31:0]         pix_b,
  output logic [CELL_W-1:0]   cell_a,
  output logic [CELL_W-1:0]   cell_b,
  output logic [OPCODE_W-1:0] opcode,
  output logic [PIXEL_W-1:0]  user_input_a,
  input  logic [PIXEL_W-1:0]  proc_pixel,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [PIXEL_W-1:0]  res_pixel,
  output logic [CNT_W-1:0]    res_index,
  output logic                busy,
  output logic                done
);

  localparam int SLOT_W = (CELL_PIXELS > 1) ? $clog2(CELL_PIXELS) : 1;
  localparam int WAIT_W = (PROC_LATENCY > 1) ? $clog2(PROC_LATENCY) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT,
    S_RESULT,
    S_DONE
  } state_t;

  state_t              state;
  logic [SLOT_W-1:0]   slot;
  logic [WAIT_W-1:0]   wait_cnt;
  logic [CNT_W-1:0]    cell_cnt;

  // The alpha byte of each incoming word is deliberately dropped.
  logic unused_alpha;
  assign unused_alpha = ^{pix_a[31:PIXEL_W], pix_b[31:PIXEL_W]};

  assign pix_ready = (state == S_LOAD);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= S_IDLE;
      slot         <= '0;
      wait_cnt     <= '0;
      cell_cnt     <= '0;
      cell_a       <= '0;
      cell_b       <= '0;
      opcode       <= '0;
      user_input_a <= '0;
      res_pixel    <= '0;
      res_index    <= '0;
      res_valid    <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort && state != S_IDLE) begin
        state     <= S_IDLE;
        res_valid <= 1'b0;
        busy      <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start) begin
              opcode       <= cfg_opcode;
              user_input_a <= cfg_user_input;
              slot         <= '0;
              cell_cnt     <= '0;
              busy         <= 1'b1;
              state        <= S_LOAD;
            end
          end
          S_LOAD: begin
            // Slots are overwritten in place, so stale data from the previous cell never leaks.
            if (pix_valid) begin
              cell_a[int'(slot)*PIXEL_W +: PIXEL_W] <= pix_a[PIXEL_W-1:0];
              cell_b[int'(slot)*PIXEL_W +: PIXEL_W] <= pix_b[PIXEL_W-1:0];
              if (slot == SLOT_W'(CELL_PIXELS - 1)) begin
                slot     <= '0;
                wait_cnt <= WAIT_W'(PROC_LATENCY - 1);
                state    <= S_WAIT;
              end else begin
                slot <= slot + SLOT_W'(1);
              end
            end
          end
          S_WAIT: begin
            if (wait_cnt == '0) begin
              res_pixel <= proc_pixel;
              res_index <= cell_cnt;
              res_valid <= 1'b1;
              state     <= S_RESULT;
            end else begin
              wait_cnt <= wait_cnt - WAIT_W'(1);
            end
          end
          S_RESULT: begin
            if (res_ready) begin
              res_valid <= 1'b0;
              cell_cnt  <= cell_cnt + CNT_W'(1);
              if (cell_cnt == CNT_W'(NUM_CELLS - 1)) begin
                done  <= 1'b1;
                state <= S_DONE;
              end else begin
                slot  <= '0;
                state <= S_LOAD;
              end
            end
          end
          S_DONE: begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end
          default: begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cell_load_sequencer.sv
// tb/tb_cell_load_sequencer.sv - directed-vector bench for cell_load_sequencer
module tb_cell_load_sequencer;

  logic         clk = 1'b0;
  logic         rst, abort, start1, start3, pix_valid, res_ready;
  logic [3:0]   cfg_opcode;
  logic [23:0]  cfg_user_input;
  logic [31:0]  pix_a, pix_b;

  logic         pix_ready1, res_valid1, busy1, done1;
  logic [215:0] cell_a1, cell_b1;
  logic [3:0]   opcode1;
  logic [23:0]  user_input_a1, proc1, res_pixel1;
  logic [15:0]  res_index1;

  logic         pix_ready3, res_valid3, busy3, done3;
  logic [215:0] cell_a3, cell_b3;
  logic [3:0]   opcode3;
  logic [23:0]  user_input_a3, proc3, res_pixel3;
  logic [15:0]  res_index3;

  int n_cmp = 0;
  int n_err = 0;
  int done_cnt = 0;

  always #5 clk = ~clk;

  // Stand-in for the CellProcessor: a simple function of the held cell vectors.
  assign proc1 = (cell_a1[23:0] + cell_b1[215:192]) ^ {20'h0, opcode1};
  assign proc3 = (cell_a3[23:0] + cell_b3[215:192]) ^ {20'h0, opcode3};

  always @(negedge clk) if (done3) done_cnt++;

  cell_load_sequencer #(.PROC_LATENCY(4), .NUM_CELLS(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .abort(abort),
    .cfg_opcode(cfg_opcode), .cfg_user_input(cfg_user_input),
    .pix_valid(pix_valid), .pix_ready(pix_ready1), .pix_a(pix_a), .pix_b(pix_b),
    .cell_a(cell_a1), .cell_b(cell_b1), .opcode(opcode1), .user_input_a(user_input_a1),
    .proc_pixel(proc1), .res_valid(res_valid1), .res_ready(res_ready),
    .res_pixel(res_pixel1), .res_index(res_index1), .busy(busy1), .done(done1)
  );

  cell_load_sequencer #(.PROC_LATENCY(4), .NUM_CELLS(3)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .abort(abort),
    .cfg_opcode(cfg_opcode), .cfg_user_input(cfg_user_input),
    .pix_valid(pix_valid), .pix_ready(pix_ready3), .pix_a(pix_a), .pix_b(pix_b),
    .cell_a(cell_a3), .cell_b(cell_b3), .opcode(opcode3), .user_input_a(user_input_a3),
    .proc_pixel(proc3), .res_valid(res_valid3), .res_ready(res_ready),
    .res_pixel(res_pixel3), .res_index(res_index3), .busy(busy3), .done(done3)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] exp_px(input logic [23:0] a0, input logic [23:0] b0,
                                         input logic [3:0] op);
    return (a0 + (b0 + 24'd8)) ^ {20'h0, op};
  endfunction

  task automatic feed(input bit sel, input logic [23:0] abase, input logic [23:0] bbase,
                      input int nbeats, input bit gap, output int cyc);
    int n;
    cyc = 0;
    n = 0;
    while (!(sel ? pix_ready3 : pix_ready1) && n < 20) begin step(); n++; end
    check("load_wait", (n < 20), 1'b1);
    for (int k = 0; k < nbeats; k++) begin
      pix_valid = 1'b1;
      pix_a = {8'hFF, abase + 24'(k)};
      pix_b = {8'h00, bbase + 24'(k)};
      step(); cyc++;
      if (gap && k < nbeats - 1) begin
        pix_valid = 1'b0;
        pix_a = 32'hDEADBEEF;
        step(); cyc++;
      end
    end
    pix_valid = 1'b0;
  endtask

  task automatic wait_res3();
    int n;
    n = 0;
    while (!res_valid3 && n < 20) begin step(); n++; end
    check("res_wait", res_valid3, 1'b1);
  endtask

  initial begin
    int cyc, base;
    bit seen;
    logic [23:0] ab, bb;
    rst = 1'b0; abort = 1'b0; start1 = 1'b0; start3 = 1'b0; pix_valid = 1'b0;
    res_ready = 1'b0; cfg_opcode = '0; cfg_user_input = '0; pix_a = '0; pix_b = '0;
    step(); step();
    check("rst_res_valid", res_valid1, 1'b0);
    check("rst_busy", busy1, 1'b0);
    check("rst_pix_ready", pix_ready3, 1'b0);
    check("rst_cell_a", cell_a1, 216'h0);
    check("rst_done", done3, 1'b0);
    rst = 1'b1;
    step();

    // Single cell on the one-cell frame, contiguous beats
    cfg_opcode = 4'h5; cfg_user_input = 24'hABCDEF; start1 = 1'b1;
    step(); start1 = 1'b0;
    check("t1_busy", busy1, 1'b1);
    check("t1_user", user_input_a1, 24'hABCDEF);
    feed(1'b0, 24'h000001, 24'h000010, 9, 1'b0, cyc);
    check("t1_cycles", cyc, 9);
    check("t1_ready_low", pix_ready1, 1'b0);
    check("t1_a_slot0", cell_a1[23:0], 24'h000001);
    check("t1_a_slot8", cell_a1[215:192], 24'h000009);
    check("t1_b_slot0", cell_b1[23:0], 24'h000010);
    check("t1_b_slot8", cell_b1[215:192], 24'h000018);
    for (int i = 1; i <= 3; i++) begin step(); check("t1_res_early", res_valid1, 1'b0); end
    step();
    check("t1_res_valid", res_valid1, 1'b1);
    check("t1_res_pixel", res_pixel1, 24'h00001C);
    check("t1_res_index", res_index1, 16'd0);
    res_ready = 1'b1;
    step(); res_ready = 1'b0;
    check("t1_done", done1, 1'b1);
    check("t1_res_drop", res_valid1, 1'b0);
    step();
    check("t1_done_once", done1, 1'b0);
    check("t1_idle", busy1, 1'b0);
    check("t1_retain", cell_a1[23:0], 24'h000001);

    // Gapped beats on the three-cell frame, then result backpressure
    cfg_opcode = 4'h6; start3 = 1'b1;
    step(); start3 = 1'b0;
    feed(1'b1, 24'h000001, 24'h000010, 9, 1'b1, cyc);
    check("t2_cycles", cyc, 17);
    check("t2_ready_low", pix_ready3, 1'b0);
    check("t2_a_slot0", cell_a3[23:0], 24'h000001);
    check("t2_a_slot8", cell_a3[215:192], 24'h000009);
    check("t2_b_slot0", cell_b3[23:0], 24'h000010);
    check("t2_b_slot8", cell_b3[215:192], 24'h000018);
    wait_res3();
    check("t2_res_pixel", res_pixel3, 24'h00001F);
    for (int i = 0; i < 10; i++) begin
      step();
      check("t3_hold", {res_valid3, pix_ready3, res_pixel3}, {1'b1, 1'b0, 24'h00001F});
    end
    res_ready = 1'b1;
    step(); res_ready = 1'b0;
    check("t3_load", pix_ready3, 1'b1);
    check("t3_res_drop", res_valid3, 1'b0);

    // Reset in the middle of a cell
    feed(1'b1, 24'h000100, 24'h000200, 5, 1'b0, cyc);
    rst = 1'b0;
    step();
    check("t5_cell_a", cell_a3, 216'h0);
    check("t5_cell_b", cell_b3, 216'h0);
    check("t5_misc", {opcode3, user_input_a3, res_pixel3, res_index3},
          {4'h0, 24'h0, 24'h0, 16'h0});
    check("t5_flags", {res_valid3, pix_ready3, busy3, done3}, 4'b0000);
    rst = 1'b1;
    step();

    // Full three-cell frame with the result side always ready
    base = done_cnt;
    res_ready = 1'b1;
    cfg_opcode = 4'h9; cfg_user_input = 24'h123456; start3 = 1'b1;
    step(); start3 = 1'b0;
    cfg_opcode = 4'hA; cfg_user_input = 24'h0;
    for (int c = 0; c < 3; c++) begin
      ab = 24'h000300 + 24'(c * 16);
      bb = 24'h000700 + 24'(c * 16);
      feed(1'b1, ab, bb, 9, 1'b0, cyc);
      if (c == 0) check("t4_fresh_slot0", cell_a3[23:0], 24'h000300);
      wait_res3();
      check("t4_res_index", res_index3, 16'(c));
      check("t4_res_pixel", res_pixel3, exp_px(ab, bb, 4'h9));
      step();
      if (c < 2) check("t4_next_load", pix_ready3, 1'b1);
      else check("t4_done", done3, 1'b1);
    end
    res_ready = 1'b0;
    step();
    check("t4_done_clear", done3, 1'b0);
    check("t4_busy", busy3, 1'b0);
    check("t4_opcode", opcode3, 4'h9);
    check("t4_user", user_input_a3, 24'h123456);
    check("t4_done_count", done_cnt - base, 1);

    // Start ignored in WAIT, then abort
    cfg_opcode = 4'h3; start3 = 1'b1;
    step(); start3 = 1'b0;
    feed(1'b1, 24'h000050, 24'h000060, 9, 1'b0, cyc);
    base = done_cnt;
    start3 = 1'b1; cfg_opcode = 4'hE;
    step(); start3 = 1'b0;
    check("t6_opcode_kept", opcode3, 4'h3);
    check("t6_busy", busy3, 1'b1);
    abort = 1'b1;
    step(); abort = 1'b0;
    check("t6_abort_idle", busy3, 1'b0);
    check("t6_abort_res", res_valid3, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin step(); if (res_valid3) seen = 1'b1; end
    check("t6_no_result", seen, 1'b0);
    check("t6_no_done", done_cnt - base, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
